// File: rtl/rggen_apb_bridge_fsm.sv
// Bridges one rggen host request to one APB4 transfer.
// All APB outputs come from registers, and the transfer can be aborted by an optional timeout.
module rggen_apb_bridge_fsm #(
  parameter int         ADDRESS_WIDTH  = 16,
  parameter int         BUS_WIDTH      = 32,
  parameter int         TIMEOUT_CYCLES = 0,
  parameter logic [2:0] PPROT_VALUE    = 3'b000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [BUS_WIDTH-1:0]     i_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_strobe,
  output logic                     o_ready,
  output logic [1:0]               o_status,
  output logic [BUS_WIDTH-1:0]     o_read_data,
  output logic                     o_timeout,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic                     o_pwrite,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr
);

  localparam int STRB_W     = BUS_WIDTH / 8;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  // Clears the byte-offset bits so that paddr is always bus-word aligned
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(STRB_W - 1);

  localparam logic [1:0] STATUS_OKAY        = 2'b00;
  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;
  logic             cnt_saturated;

  // The abort happens on the cycle where the counter would reach TIMEOUT_CYCLES
  assign timeout_hit   = TIMEOUT_EN && (cnt_reg == CNT_LAST);
  assign cnt_saturated = (cnt_reg == {CNT_W{1'b1}});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      o_ready     <= 1'b0;
      o_status    <= '0;
      o_read_data <= '0;
      o_timeout   <= 1'b0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_paddr     <= '0;
      o_pprot     <= '0;
      o_pwrite    <= 1'b0;
      o_pstrb     <= '0;
      o_pwdata    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            o_psel    <= 1'b1;
            o_pwrite  <= i_write;
            o_paddr   <= i_address & ADDR_MASK;
            o_pprot   <= PPROT_VALUE;
            o_pstrb   <= i_write ? i_strobe : '0;
            o_pwdata  <= i_write ? i_write_data : '0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (i_pready || timeout_hit) begin
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_paddr   <= '0;
            o_pprot   <= '0;
            o_pwrite  <= 1'b0;
            o_pstrb   <= '0;
            o_pwdata  <= '0;
            o_ready   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= RESPONSE;
            // A slave answer on the expiry cycle takes priority over the abort
            if (i_pready) begin
              o_status    <= i_pslverr ? STATUS_SLAVE_ERROR : STATUS_OKAY;
              o_read_data <= o_pwrite ? '0 : i_prdata;
              o_timeout   <= 1'b0;
            end else begin
              o_status    <= STATUS_SLAVE_ERROR;
              o_read_data <= '0;
              o_timeout   <= 1'b1;
            end
          end else if (TIMEOUT_EN && !cnt_saturated) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESPONSE: begin
          o_ready   <= 1'b0;
          o_timeout <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rggen_apb_bridge_fsm.md
Name: rggen_apb_bridge_fsm

Overview:
Parametrised successor to the rggen APB bridge. Converts one rggen bus request into one APB4 transfer. Registers every APB request output, so no combinational path runs from host to APB. Returns registered read data and status, and aborts with an error if the APB slave never responds within a configurable timeout. Sits between the register-block host bus and an APB4 subordinate region.

Parameters:
ADDRESS_WIDTH, 16, width of i_address / o_paddr in bits
BUS_WIDTH, 32, data width in bits (32 or 64); strobe width = BUS_WIDTH/8
TIMEOUT_CYCLES, 0, max ACCESS cycles with pready low before abort; 0 disables the timeout
PPROT_VALUE, 3'b000, constant driven on o_pprot during a transfer

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  host request valid; held until o_ready
i_write  input  1  1 = write, 0 = read
i_address  input  ADDRESS_WIDTH  byte address
i_write_data  input  BUS_WIDTH  write data
i_strobe  input  BUS_WIDTH/8  byte enables
o_ready  output  1  one-cycle response pulse
o_status  output  2  00 OKAY, 10 SLAVE_ERROR (rggen_status encoding)
o_read_data  output  BUS_WIDTH  read data, valid with o_ready
o_timeout  output  1  one-cycle pulse, concurrent with o_ready, when the transfer was aborted
o_psel  output  1  APB psel
o_penable  output  1  APB penable
o_paddr  output  ADDRESS_WIDTH  APB paddr, low log2(BUS_WIDTH/8) bits forced to 0
o_pprot  output  3  APB pprot
o_pwrite  output  1  APB pwrite
o_pstrb  output  BUS_WIDTH/8  APB pstrb; all-zero on reads
o_pwdata  output  BUS_WIDTH  APB pwdata; all-zero on reads
i_pready  input  1  APB pready
i_prdata  input  BUS_WIDTH  APB prdata
i_pslverr  input  1  APB pslverr

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-transfer drops psel/penable immediately (asynchronously). No response is issued for the killed transfer.
- IDLE: if i_valid=1, capture address, write, strobe and data into the APB output registers, set psel=1, go to SETUP. Otherwise all APB outputs stay 0.
- SETUP: psel=1, penable=0; next state ACCESS (penable=1). pready is ignored in SETUP.
- ACCESS: psel=penable=1; APB outputs held stable.
  - pready=1: capture prdata (reads only; writes return 0) and status (pslverr ? 10 : 00), drop psel/penable, go to RESPONSE.
  - pready=0 with TIMEOUT_CYCLES>0: counter increments.
  - Counter reaching TIMEOUT_CYCLES with pready still 0: drop psel/penable, set status 10, read data 0, flag timeout, go to RESPONSE.
  - pready=1 on the same cycle the counter would expire: normal completion wins.
- RESPONSE: o_ready=1 for exactly one cycle, with o_status/o_read_data (and o_timeout if aborted). Next state IDLE; counter cleared.
- o_status/o_read_data hold their last values outside RESPONSE; they are valid only while o_ready=1.
- Minimum latency: i_valid seen in IDLE at cycle 0 -> psel cycle 1 -> penable cycle 2 -> o_ready cycle 3 with zero wait states. Each wait state adds one cycle.
- Back-to-back: i_valid held high in the cycle after o_ready is treated as a new request. IDLE always lasts at least one cycle between transfers, so psel is low for at least 2 cycles between transfers.
- Request fields are sampled only in IDLE; host changes afterwards have no effect on the transfer in flight.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. The counter saturates and never wraps.

Test Plan:
- Zero-wait write: addr 0x0014, data 0xDEADBEEF, strb 4'hF, pready=1 first ACCESS cycle -> psel cycle 1, penable cycle 2, o_ready cycle 3, status 00, pwdata 0xDEADBEEF, pstrb 4'hF.
- Read with 3 wait states: prdata 0x12345678 -> o_ready at cycle 6, read_data 0x12345678, pstrb 0, pwdata 0.
- Slave error: read, pready=1 with pslverr=1 -> status 10, o_timeout 0.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> ACCESS cycles 2-5, psel low and o_ready=o_timeout=1 at cycle 6, status 10, read_data 0. Then pready=1 on the 4th ACCESS cycle -> normal OKAY completion.
- Back-to-back: i_valid held high across two writes -> two separate APB transfers, psel low ≥2 cycles between them, two o_ready pulses.
- Reset mid-ACCESS: deassert i_rst_n -> psel/penable/o_ready 0 immediately, FSM IDLE. After release, a new read completes normally.
